// File: rtl/ro_buffer_pkg.sv
// Shared configuration for the reorder buffer: sizing, ID type, instruction kinds and the entry record.
// Entry IDs run 1..RO_BUFFER_SIZE; ID 0 is reserved to mean "no tag".
package ro_buffer_pkg;

    localparam int RO_BUFFER_SIZE         = 16;
    localparam int RO_BUFFER_SIZE_PLUS_1  = RO_BUFFER_SIZE + 1;
    localparam int RO_BUFFER_SIZE_MINUS_1 = RO_BUFFER_SIZE - 1;
    localparam int ID_WIDTH               = 5;

    typedef logic [ID_WIDTH-1:0] ro_buffer_id_t;

    typedef enum logic [1:0] {
        KIND_ALU    = 2'd0,
        KIND_BRANCH = 2'd1,
        KIND_STORE  = 2'd2,
        KIND_LOAD   = 2'd3
    } kind_e;

    typedef struct packed {
        logic        busy;
        logic        ready;
        kind_e       kind;
        logic [4:0]  rd;
        logic [31:0] pred_pc;
        logic [31:0] value;
        logic [31:0] next_pc;
    } rob_entry_t;

endpackage

// File: rtl/ro_buffer.sv
// In-order reorder buffer: allocates at tail, captures rss/lsb write-backs, retires one ready head per cycle
// (registered, 1-cycle pulses); a mispredicted branch pulses the flush and the buffer clears on the next edge.
module ro_buffer
    import ro_buffer_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          rdy,
    input  logic          alloc_from_issuer,
    input  logic [1:0]    kind_from_issuer,
    input  logic [4:0]    rd_from_issuer,
    input  logic [31:0]   pred_pc_from_issuer,
    output ro_buffer_id_t dest_to_issuer,
    output logic          is_ro_buffer_full,
    input  ro_buffer_id_t dest_from_rss_bus,
    input  logic [31:0]   value_from_rss_bus,
    input  logic [31:0]   next_pc_from_rss_bus,
    input  ro_buffer_id_t dest_from_lsb_bus,
    input  logic [31:0]   value_from_lsb_bus,
    input  ro_buffer_id_t query_j_id,
    input  ro_buffer_id_t query_k_id,
    output logic          query_j_ready,
    output logic          query_k_ready,
    output logic [31:0]   query_j_value,
    output logic [31:0]   query_k_value,
    output logic [4:0]    rd_to_reg_file,
    output logic [31:0]   value_to_reg_file,
    output ro_buffer_id_t dest_to_reg_file,
    output ro_buffer_id_t store_commit_to_lsb,
    output logic          reset_to_rob_bus,
    output logic [31:0]   target_pc_to_fetcher
);

    localparam ro_buffer_id_t FIRST_ID = ro_buffer_id_t'(1);
    localparam ro_buffer_id_t LAST_ID  = ro_buffer_id_t'(RO_BUFFER_SIZE);
    localparam ro_buffer_id_t FULL_AT  = ro_buffer_id_t'(RO_BUFFER_SIZE_MINUS_1);

    function automatic ro_buffer_id_t next_id(input ro_buffer_id_t id);
        return (id == LAST_ID) ? FIRST_ID : id + FIRST_ID;
    endfunction

    function automatic logic id_valid(input ro_buffer_id_t id);
        return (id != '0) && (id <= LAST_ID);
    endfunction

    rob_entry_t    rob_q [1:RO_BUFFER_SIZE];
    rob_entry_t    rob_d [1:RO_BUFFER_SIZE];
    ro_buffer_id_t head_q, head_d, tail_q, tail_d, count_q, count_d;
    logic [4:0]    rd_q, rd_d;
    logic [31:0]   value_q, value_d, target_q, target_d;
    ro_buffer_id_t dest_q, dest_d, store_q, store_d;
    logic          flush_q, flush_d;

    logic          alloc_acc;
    logic          retire;
    rob_entry_t    head_ent;

    assign is_ro_buffer_full = (count_q >= FULL_AT);
    assign dest_to_issuer    = tail_q;
    assign alloc_acc         = alloc_from_issuer && !is_ro_buffer_full;

    always_comb begin
        rob_d    = rob_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        rd_d     = '0;
        value_d  = '0;
        dest_d   = '0;
        store_d  = '0;
        flush_d  = 1'b0;
        target_d = '0;
        retire   = 1'b0;
        head_ent = rob_q[head_q];

        if (flush_q) begin
            // The cycle after a mispredict pulse behaves exactly like reset; this cycle's inputs are dropped.
            for (int i = 1; i <= RO_BUFFER_SIZE; i++) rob_d[i] = '0;
            head_d  = FIRST_ID;
            tail_d  = FIRST_ID;
            count_d = '0;
        end else begin
            for (int i = 1; i <= RO_BUFFER_SIZE; i++) begin
                if (rob_q[i].busy && dest_from_rss_bus == ro_buffer_id_t'(i)) begin
                    rob_d[i].value = value_from_rss_bus;
                    rob_d[i].ready = 1'b1;
                    if (rob_q[i].kind == KIND_BRANCH) rob_d[i].next_pc = next_pc_from_rss_bus;
                end
                if (rob_q[i].busy && dest_from_lsb_bus == ro_buffer_id_t'(i)) begin
                    rob_d[i].value = value_from_lsb_bus;
                    rob_d[i].ready = 1'b1;
                end
            end

            if (head_ent.busy && head_ent.ready) begin
                retire = 1'b1;
                if (head_ent.kind == KIND_STORE) begin
                    store_d = head_q;
                end else begin
                    rd_d    = head_ent.rd;
                    value_d = head_ent.value;
                    dest_d  = head_q;
                    if (head_ent.kind == KIND_BRANCH && head_ent.next_pc != head_ent.pred_pc) begin
                        flush_d  = 1'b1;
                        target_d = head_ent.next_pc;
                    end
                end
                rob_d[head_q] = '0;
                head_d        = next_id(head_q);
            end

            if (alloc_acc) begin
                rob_d[tail_q] = '{busy: 1'b1, ready: 1'b0, kind: kind_e'(kind_from_issuer),
                                  rd: rd_from_issuer, pred_pc: pred_pc_from_issuer,
                                  value: 32'd0, next_pc: 32'd0};
                tail_d = next_id(tail_q);
            end

            count_d = count_q + ro_buffer_id_t'(alloc_acc) - ro_buffer_id_t'(retire);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i <= RO_BUFFER_SIZE; i++) rob_q[i] <= '0;
            head_q   <= FIRST_ID;
            tail_q   <= FIRST_ID;
            count_q  <= '0;
            rd_q     <= '0;
            value_q  <= '0;
            dest_q   <= '0;
            store_q  <= '0;
            flush_q  <= 1'b0;
            target_q <= '0;
        end else if (rdy) begin
            rob_q    <= rob_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            rd_q     <= rd_d;
            value_q  <= value_d;
            dest_q   <= dest_d;
            store_q  <= store_d;
            flush_q  <= flush_d;
            target_q <= target_d;
        end
    end

    assign rd_to_reg_file       = rd_q;
    assign value_to_reg_file    = value_q;
    assign dest_to_reg_file     = dest_q;
    assign store_commit_to_lsb  = store_q;
    assign reset_to_rob_bus     = flush_q;
    assign target_pc_to_fetcher = target_q;

    // Operand lookup: a stored result wins, otherwise a same-cycle bus hit is bypassed.
    function automatic logic [32:0] lookup(input ro_buffer_id_t id, input rob_entry_t ent,
                                           input ro_buffer_id_t rss_tag, input logic [31:0] rss_val,
                                           input ro_buffer_id_t lsb_tag, input logic [31:0] lsb_val);
        logic [32:0] res;
        res = '0;
        if (id_valid(id)) begin
            if (ent.ready)           res = {1'b1, ent.value};
            else if (id == rss_tag)  res = {1'b1, rss_val};
            else if (id == lsb_tag)  res = {1'b1, lsb_val};
        end
        return res;
    endfunction

    logic [32:0] j_res, k_res;
    rob_entry_t  j_ent, k_ent;

    always_comb begin
        j_ent = '0;
        k_ent = '0;
        if (id_valid(query_j_id)) j_ent = rob_q[query_j_id];
        if (id_valid(query_k_id)) k_ent = rob_q[query_k_id];
        j_res = lookup(query_j_id, j_ent, dest_from_rss_bus, value_from_rss_bus,
                       dest_from_lsb_bus, value_from_lsb_bus);
        k_res = lookup(query_k_id, k_ent, dest_from_rss_bus, value_from_rss_bus,
                       dest_from_lsb_bus, value_from_lsb_bus);
    end

    assign query_j_ready = j_res[32];
    assign query_j_value = j_res[31:0];
    assign query_k_ready = k_res[32];
    assign query_k_value = k_res[31:0];

endmodule

// File: tb/tb_ro_buffer.sv
// Scoreboard bench for ro_buffer: expected retirements are queued as stimulus is issued and
// popped by a negedge monitor whenever the buffer presents a commit, store release or flush.
module tb_ro_buffer;
    import ro_buffer_pkg::*;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rdy = 1'b1;
    logic          alloc_from_issuer = 1'b0;
    logic [1:0]    kind_from_issuer = '0;
    logic [4:0]    rd_from_issuer = '0;
    logic [31:0]   pred_pc_from_issuer = '0;
    ro_buffer_id_t dest_to_issuer;
    logic          is_ro_buffer_full;
    ro_buffer_id_t dest_from_rss_bus = '0;
    logic [31:0]   value_from_rss_bus = '0;
    logic [31:0]   next_pc_from_rss_bus = '0;
    ro_buffer_id_t dest_from_lsb_bus = '0;
    logic [31:0]   value_from_lsb_bus = '0;
    ro_buffer_id_t query_j_id = '0;
    ro_buffer_id_t query_k_id = '0;
    logic          query_j_ready, query_k_ready;
    logic [31:0]   query_j_value, query_k_value;
    logic [4:0]    rd_to_reg_file;
    logic [31:0]   value_to_reg_file;
    ro_buffer_id_t dest_to_reg_file;
    ro_buffer_id_t store_commit_to_lsb;
    logic          reset_to_rob_bus;
    logic [31:0]   target_pc_to_fetcher;

    ro_buffer dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .alloc_from_issuer(alloc_from_issuer), .kind_from_issuer(kind_from_issuer),
        .rd_from_issuer(rd_from_issuer), .pred_pc_from_issuer(pred_pc_from_issuer),
        .dest_to_issuer(dest_to_issuer), .is_ro_buffer_full(is_ro_buffer_full),
        .dest_from_rss_bus(dest_from_rss_bus), .value_from_rss_bus(value_from_rss_bus),
        .next_pc_from_rss_bus(next_pc_from_rss_bus),
        .dest_from_lsb_bus(dest_from_lsb_bus), .value_from_lsb_bus(value_from_lsb_bus),
        .query_j_id(query_j_id), .query_k_id(query_k_id),
        .query_j_ready(query_j_ready), .query_k_ready(query_k_ready),
        .query_j_value(query_j_value), .query_k_value(query_k_value),
        .rd_to_reg_file(rd_to_reg_file), .value_to_reg_file(value_to_reg_file),
        .dest_to_reg_file(dest_to_reg_file), .store_commit_to_lsb(store_commit_to_lsb),
        .reset_to_rob_bus(reset_to_rob_bus), .target_pc_to_fetcher(target_pc_to_fetcher)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          is_store;
        ro_buffer_id_t id;
        logic [4:0]    rd;
        logic [31:0]   value;
        logic          flush;
        logic [31:0]   target;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_commit(input ro_buffer_id_t id, input logic [4:0] rd, input logic [31:0] v);
        exp_q.push_back('{is_store: 1'b0, id: id, rd: rd, value: v, flush: 1'b0, target: 32'd0});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        alloc_from_issuer = 1'b0;
        dest_from_rss_bus = '0;
        dest_from_lsb_bus = '0;
    endtask

    task automatic alloc(input kind_e k, input logic [4:0] rd, input logic [31:0] pred);
        alloc_from_issuer   = 1'b1;
        kind_from_issuer    = k;
        rd_from_issuer      = rd;
        pred_pc_from_issuer = pred;
    endtask

    task automatic drain();
        for (int n = 0; n < 40 && exp_q.size() != 0; n++) tick();
        repeat (2) tick();
    endtask

    // Monitor: every presented commit must match the head of the scoreboard queue.
    always @(negedge clk) begin
        if (!rst && rdy && (dest_to_reg_file != '0 || store_commit_to_lsb != '0 || reset_to_rob_bus)) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_commit: got dest=%0d store=%0d flush=%0b expected none at %0t",
                         dest_to_reg_file, store_commit_to_lsb, reset_to_rob_bus, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("commit_rd", 32'(rd_to_reg_file), e.is_store ? 32'd0 : 32'(e.rd));
                check("commit_flush", 32'(reset_to_rob_bus), 32'(e.flush));
                if (e.is_store) begin
                    check("store_commit_id", 32'(store_commit_to_lsb), 32'(e.id));
                end else begin
                    check("commit_dest", 32'(dest_to_reg_file), 32'(e.id));
                    check("commit_value", value_to_reg_file, e.value);
                    check("commit_store_idle", 32'(store_commit_to_lsb), 32'd0);
                end
                if (e.flush) check("flush_target", target_pc_to_fetcher, e.target);
            end
        end
    end

    initial begin
        ro_buffer_id_t id;

        // 1: reset state, then three ALU allocations
        tick();
        tick();
        rst = 1'b0;
        check("rst_dest_to_issuer", 32'(dest_to_issuer), 32'd1);
        check("rst_full", 32'(is_ro_buffer_full), 32'd0);
        check("rst_rd_out", 32'(rd_to_reg_file), 32'd0);
        check("rst_flush", 32'(reset_to_rob_bus), 32'd0);
        check("rst_target", target_pc_to_fetcher, 32'd0);
        check("rst_query_id0", 32'(query_j_ready), 32'd0);
        for (int i = 1; i <= 3; i++) begin
            check("alloc_dest", 32'(dest_to_issuer), 32'(i));
            alloc(KIND_ALU, 5'(i), 32'd0);
            tick();
        end
        check("after3_dest", 32'(dest_to_issuer), 32'd4);
        repeat (3) tick();

        // 2: out-of-order write-backs, in-order retirement
        dest_from_rss_bus = 5'd2; value_from_rss_bus = 32'd7;
        tick();
        query_j_id = 5'd2; query_k_id = 5'd3;
        #1;
        check("q_stored_rdy", 32'(query_j_ready), 32'd1);
        check("q_stored_val", query_j_value, 32'd7);
        check("q_notready", 32'(query_k_ready), 32'd0);
        push_commit(5'd1, 5'd1, 32'd5);
        push_commit(5'd2, 5'd2, 32'd7);
        dest_from_rss_bus = 5'd1; value_from_rss_bus = 32'd5;
        query_k_id = 5'd1;
        #1;
        check("q_bypass_rdy", 32'(query_k_ready), 32'd1);
        check("q_bypass_val", query_k_value, 32'd5);
        tick();
        push_commit(5'd3, 5'd3, 32'd9);
        dest_from_rss_bus = 5'd3; value_from_rss_bus = 32'd9;
        tick();
        drain();

        // 6: store release via lsb alongside an rss bypass query
        alloc(KIND_STORE, 5'd0, 32'd0);
        tick();
        alloc(KIND_ALU, 5'd5, 32'd0);
        tick();
        exp_q.push_back('{is_store: 1'b1, id: 5'd4, rd: 5'd0, value: 32'd0, flush: 1'b0, target: 32'd0});
        push_commit(5'd5, 5'd5, 32'h55);
        dest_from_lsb_bus = 5'd4; value_from_lsb_bus = 32'hAA;
        dest_from_rss_bus = 5'd5; value_from_rss_bus = 32'h55;
        query_j_id = 5'd5;
        #1;
        check("q_rss_bus_rdy", 32'(query_j_ready), 32'd1);
        check("q_rss_bus_val", query_j_value, 32'h55);
        tick();
        drain();

        // 3/4: fill to the pre-full threshold, wrapping the tail 16 -> 1
        for (int n = 0; n < 15; n++) begin
            id = ro_buffer_id_t'(((5 + n) % 16) + 1);
            check("fill_dest", 32'(dest_to_issuer), 32'(id));
            check("fill_not_full", 32'(is_ro_buffer_full), 32'd0);
            alloc(KIND_ALU, id, 32'd0);
            tick();
        end
        check("full_flag", 32'(is_ro_buffer_full), 32'd1);
        check("full_dest", 32'(dest_to_issuer), 32'd5);
        alloc(KIND_ALU, 5'd31, 32'd0);
        tick();
        check("full_alloc_ignored", 32'(dest_to_issuer), 32'd5);
        query_j_id = 5'd1;
        #1;
        check("wrapped_id1_notready", 32'(query_j_ready), 32'd0);
        push_commit(5'd6, 5'd6, 32'h106);
        dest_from_rss_bus = 5'd6; value_from_rss_bus = 32'h106;
        tick();
        push_commit(5'd7, 5'd7, 32'h107);
        dest_from_rss_bus = 5'd7; value_from_rss_bus = 32'h107;
        tick();
        check("after_retire_not_full", 32'(is_ro_buffer_full), 32'd0);
        alloc(KIND_ALU, 5'd5, 32'd0);
        tick();
        check("alloc_retire_dest", 32'(dest_to_issuer), 32'd6);
        check("alloc_retire_count_kept", 32'(is_ro_buffer_full), 32'd0);
        alloc(KIND_ALU, 5'd6, 32'd0);
        tick();
        check("refull_flag", 32'(is_ro_buffer_full), 32'd1);
        for (int n = 0; n < 15; n++) begin
            id = ro_buffer_id_t'(((7 + n) % 16) + 1);
            push_commit(id, 5'(id), 32'h100 + 32'(id));
            dest_from_rss_bus = id; value_from_rss_bus = 32'h100 + 32'(id);
            tick();
        end
        drain();

        // 5: mispredicted branch flushes the buffer
        alloc(KIND_BRANCH, 5'd1, 32'h104);
        tick();
        alloc(KIND_ALU, 5'd2, 32'd0);
        tick();
        exp_q.push_back('{is_store: 1'b0, id: 5'd7, rd: 5'd1, value: 32'h108, flush: 1'b1, target: 32'h200});
        dest_from_rss_bus = 5'd7; value_from_rss_bus = 32'h108; next_pc_from_rss_bus = 32'h200;
        dest_from_lsb_bus = 5'd8; value_from_lsb_bus = 32'h88;
        tick();
        tick();
        alloc(KIND_ALU, 5'd9, 32'd0);
        tick();
        query_j_id = 5'd8; query_k_id = 5'd7;
        #1;
        check("flush_dest", 32'(dest_to_issuer), 32'd1);
        check("flush_not_full", 32'(is_ro_buffer_full), 32'd0);
        check("flush_q8_cleared", 32'(query_j_ready), 32'd0);
        check("flush_pulse_done", 32'(reset_to_rob_bus), 32'd0);

        // correctly predicted branch retires without a flush
        alloc(KIND_BRANCH, 5'd3, 32'h300);
        tick();
        push_commit(5'd1, 5'd3, 32'h33);
        dest_from_rss_bus = 5'd1; value_from_rss_bus = 32'h33; next_pc_from_rss_bus = 32'h300;
        tick();
        drain();

        // rdy low freezes allocation
        rdy = 1'b0;
        alloc(KIND_ALU, 5'd4, 32'd0);
        tick();
        check("rdy_low_hold", 32'(dest_to_issuer), 32'd2);
        rdy = 1'b1;
        tick();
        check("rdy_restore_dest", 32'(dest_to_issuer), 32'd2);

        for (int n = 0; n < 60 && exp_q.size() != 0; n++) tick();
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        repeat (4) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
